// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory arbiter and its storage array.
package dmem_pkg;

  localparam int DMEM_AWIDTH  = 32;
  localparam int DMEM_ALENGTH = 128;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  // Request captured at acceptance; fields are sized for the default data width.
  typedef struct packed {
    logic                   port;
    logic                   we;
    logic [DMEM_AWIDTH-1:0] addr;
    logic [DMEM_AWIDTH-1:0] wdata;
  } req_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side bus (two ports sharing one response path) and storage-array bus.
interface dmem_req_if #(
  parameter int AWIDTH = dmem_pkg::DMEM_AWIDTH
) ();
  logic [1:0]        ReqVal;
  logic [1:0]        ReqRdy;
  logic [1:0]        ReqWE;
  logic [AWIDTH-1:0] Addr0;
  logic [AWIDTH-1:0] Addr1;
  logic [AWIDTH-1:0] WriDat0;
  logic [AWIDTH-1:0] WriDat1;
  logic [1:0]        RspVal;
  logic [AWIDTH-1:0] ReaDat;
  logic              RspErr;

  modport master (
    output ReqVal, ReqWE, Addr0, Addr1, WriDat0, WriDat1,
    input  ReqRdy, RspVal, ReaDat, RspErr
  );

  modport slave (
    input  ReqVal, ReqWE, Addr0, Addr1, WriDat0, WriDat1,
    output ReqRdy, RspVal, ReaDat, RspErr
  );
endinterface

interface dmem_mem_if #(
  parameter int AWIDTH = dmem_pkg::DMEM_AWIDTH
) ();
  logic              MemWE;
  logic [AWIDTH-1:0] MemAddr;
  logic [AWIDTH-1:0] MemWriDat;
  logic [AWIDTH-1:0] MemReaDat;

  modport master (
    output MemWE, MemAddr, MemWriDat,
    input  MemReaDat
  );

  modport slave (
    input  MemWE, MemAddr, MemWriDat,
    output MemReaDat
  );
endinterface

// File: rtl/dmem_array.sv
// Data-memory storage: synchronous write, registered read (one-cycle latency).
module dmem_array
  import dmem_pkg::*;
#(
  parameter int AWIDTH  = DMEM_AWIDTH,
  parameter int ALENGTH = DMEM_ALENGTH
) (
  input logic       clk,
  dmem_mem_if.slave mem
);

  localparam int IW = (ALENGTH > 1) ? $clog2(ALENGTH) : 1;

  logic [AWIDTH-1:0] r_mem [ALENGTH];
  logic [AWIDTH-1:0] r_rdata;
  logic              w_in_range;
  logic [IW-1:0]     w_idx;

  assign w_in_range = mem.MemAddr < AWIDTH'(ALENGTH);
  assign w_idx      = w_in_range ? mem.MemAddr[IW-1:0] : '0;

  // NOTE: the storage array has no reset; clearing it would need one write port per word.
  always_ff @(posedge clk) begin
    if (mem.MemWE && w_in_range) begin
      r_mem[w_idx] <= mem.MemWriDat;
    end
    r_rdata <= r_mem[w_idx];
  end

  assign mem.MemReaDat = r_rdata;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: IDLE -> ACCESS -> RESP per transaction.
// Define DMEM_ARB_RR_EN for round-robin arbitration; default is fixed priority to port 0.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int AWIDTH  = DMEM_AWIDTH,
  parameter int ALENGTH = DMEM_ALENGTH
) (
  input logic        clk,
  input logic        rst,
  dmem_req_if.slave  req,
  dmem_mem_if.master mem
);

  localparam logic [DMEM_AWIDTH-1:0] ALEN = DMEM_AWIDTH'(ALENGTH);

  state_t     r_state;
  req_t       r_req;
  logic [1:0] r_rsp_val;
  logic       r_rsp_err;
  logic       r_rd_ok;

  logic       w_win;
  logic       w_accept;
  logic       w_addr_oob;
  logic       w_addr_zero;
  logic       w_fault;

`ifdef DMEM_ARB_RR_EN
  logic r_rr_ptr;

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_win = 1'b0;
    if (&req.ReqVal) w_win = r_rr_ptr;
    else             w_win = req.ReqVal[1];
  end
`else
  always_comb begin
    w_win = 1'b0;
    if (!req.ReqVal[0]) w_win = 1'b1;
  end
`endif

  assign w_accept   = (r_state == IDLE) && !rst && (|req.ReqVal);
  assign req.ReqRdy = w_accept ? (w_win ? 2'b10 : 2'b01) : 2'b00;

  // Full-width compare: an address is never wrapped into the array.
  assign w_addr_oob  = r_req.addr >= ALEN;
  assign w_addr_zero = r_req.addr == '0;
  assign w_fault     = w_addr_oob || (r_req.we && w_addr_zero);

  // Reset in ACCESS kills the write in the same cycle.
  assign mem.MemWE     = (r_state == ACCESS) && r_req.we && !w_fault && !rst;
  assign mem.MemAddr   = AWIDTH'(r_req.addr);
  assign mem.MemWriDat = AWIDTH'(r_req.wdata);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_req     <= '0;
      r_rsp_val <= 2'b00;
      r_rsp_err <= 1'b0;
      r_rd_ok   <= 1'b0;
`ifdef DMEM_ARB_RR_EN
      r_rr_ptr  <= 1'b0;
`endif
    end else begin
      r_rsp_val <= 2'b00;
      r_rsp_err <= 1'b0;
      r_rd_ok   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_req.port  <= w_win;
            r_req.we    <= req.ReqWE[w_win];
            r_req.addr  <= DMEM_AWIDTH'(w_win ? req.Addr1 : req.Addr0);
            r_req.wdata <= DMEM_AWIDTH'(w_win ? req.WriDat1 : req.WriDat0);
            r_state     <= ACCESS;
`ifdef DMEM_ARB_RR_EN
            r_rr_ptr    <= ~w_win;
`endif
          end
        end
        ACCESS: begin
          r_rsp_val <= r_req.port ? 2'b10 : 2'b01;
          r_rsp_err <= w_fault;
          r_rd_ok   <= !r_req.we && !w_addr_oob && !w_addr_zero;
          r_state   <= RESP;
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Read data passes straight from the array in RESP; word 0 and faults read as 0.
  assign req.RspVal = rst ? 2'b00 : r_rsp_val;
  assign req.RspErr = r_rsp_err && !rst;
  assign req.ReaDat = (r_rd_ok && !rst) ? mem.MemReaDat : '0;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter AWIDTH, default 32: address and data width in bits.
REQ-002 Parameter ALENGTH, default 128: number of data-memory words; addresses are word indices.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 ReqVal  input  2  request valid per port; bit 0 is the CPU load/store port and bit 1 is the debug/DMA port.
REQ-006 ReqRdy  output  2  request accepted per port; a transfer occurs when ReqVal[i] and ReqRdy[i] are both 1.
REQ-007 ReqWE  input  2  per-port write enable; 1 means write and 0 means read.
REQ-008 Addr0, Addr1  input  AWIDTH  per-port word address.
REQ-009 WriDat0, WriDat1  input  AWIDTH  per-port write data.
REQ-010 RspVal  output  2  one-cycle response pulse per port.
REQ-011 ReaDat  output  AWIDTH  read data, valid while any RspVal bit is 1.
REQ-012 RspErr  output  1  error flag, valid with RspVal: address out of range, or a write to word 0.
REQ-013 MemWE, MemAddr, MemWriDat  output  1/AWIDTH/AWIDTH  drive the storage array.
REQ-014 MemReaDat  input  AWIDTH  array read data, one cycle after MemAddr is presented.

Function
REQ-015 State machine states: IDLE, ACCESS, RESP.
- IDLE -> ACCESS on any accepted request.
- ACCESS -> RESP unconditionally.
- RESP -> IDLE unconditionally.
REQ-016 In IDLE, exactly one ReqRdy bit is 1, combinationally, for the arbitration winner among asserted ReqVal bits; ReqRdy is 0 when no ReqVal bit is set and in all other states.
REQ-017 On acceptance, the winner index, ReqWE, address and write data are registered; the inputs may change afterwards.
REQ-018 In ACCESS, MemAddr is the registered address and MemWriDat is the registered write data.
REQ-019 In ACCESS, MemWE is 1 only for a write with address in 1..ALENGTH-1; otherwise MemWE is 0.
REQ-020 In RESP, RspVal[winner] is 1 for exactly one cycle.
REQ-021 In RESP, ReaDat carries MemReaDat for an in-range read and 0 for writes and faulted reads.
REQ-022 Word 0 always reads as 0, whatever the array contents.
REQ-023 RspErr is 1 for any address >= ALENGTH and for any write to address 0; a faulted access never asserts MemWE.
REQ-024 Latency: acceptance at edge N gives ACCESS in cycle N+1 and RspVal in cycle N+2; peak throughput is one transaction per 3 cycles.
REQ-025 Requests that arrive while not in IDLE wait, with ReqRdy 0; a requester holds ReqVal and its fields stable until accepted.
REQ-026 Address comparison uses the full AWIDTH bits; the address is never truncated or wrapped.
REQ-027 Outside ACCESS, MemWE is 0 and MemAddr and MemWriDat hold their last values.

Reset
REQ-028 While rst is 1, the state is IDLE at the next edge.
REQ-029 During reset, ReqRdy=0, RspVal=0, RspErr=0, ReaDat=0 and MemWE=0.
REQ-030 The round-robin pointer resets so that port 0 has priority.
REQ-031 rst asserted during ACCESS gates MemWE to 0 in that same cycle, so no partial write commits; the pending response is discarded.

Configuration
REQ-032 Macro DMEM_ARB_RR_EN defined: round-robin arbitration; the pointer moves to the other port after each grant, so on simultaneous requests the port not granted most recently wins.
REQ-033 Macro DMEM_ARB_RR_EN undefined: fixed priority; port 0 always wins simultaneous requests, and no pointer register is built.

Structure
REQ-034 Package dmem_pkg holds:
- AWIDTH and ALENGTH defaults;
- the state enum (IDLE, ACCESS, RESP);
- the registered-request struct (port, we, addr, wdata).
REQ-035 The storage array is the sub-module dmem_array: synchronous write and registered read, instantiated beside dmem_arbiter in the test harness and not inside it.

Verification
REQ-036 Reset: hold rst 2 cycles with both ReqVal bits 1 -> ReqRdy=00, RspVal=00 and MemWE=0 throughout.
REQ-037 Write then read: port 0 writes 0xDEADBEEF to word 5, then reads word 5 -> write RspVal[0] at N+2 with RspErr=0; read ReaDat=0xDEADBEEF.
REQ-038 Protected word: write 0x1234 to word 0, then read it -> MemWE stays 0, RspErr=1 on the write, and the read returns 0.
REQ-039 Out of range: read address 128 and write address 0xFFFFFFFF -> RspErr=1 on both, ReaDat=0 and MemWE=0.
REQ-040 Contention: both ports request each cycle for 6 transactions.
- With DMEM_ARB_RR_EN: grants alternate 0,1,0,1,0,1.
- Without it: six grants to port 0 and port 1 starved.
REQ-041 Reset mid-op: assert rst in the ACCESS cycle of a write to word 7 -> word 7 keeps its old value and no RspVal pulse follows.
